// File: rtl/fft_mem_pkg.sv
// fft_mem_pkg: shared write-permutation modes, counter sizing and permutation helper for FFT memory address generators
package fft_mem_pkg;
  typedef enum logic [1:0] {
    MODE_LIN = 2'b00,
    MODE_ROT = 2'b01,
    MODE_REV = 2'b10
  } mode_e;
  localparam int DefAddrWidth = 5;
  localparam int DefNumBanks = 4;
  function automatic int cnt_width(input int addr_w, input int banks);
    return addr_w + $clog2(banks);
  endfunction
  localparam int DefCntW = DefAddrWidth + $clog2(DefNumBanks);
  typedef logic [DefCntW-1:0] cnt_t;
  // Permutes the low n (<= 8) bits of v; 2'b11 and any other code fall through to linear.
  function automatic logic [7:0] permute(input logic [7:0] v, input int n, input mode_e m);
    logic [7:0] r;
    logic [2:0] b, nb, rb;
    r = v;
    for (int i = 0; i < 8; i++) begin
      b = 3'(i);
      nb = 3'(i + 1);
      rb = 3'(n - 1 - i);
      if (i < n) r[b] = m == MODE_ROT ? (i == n - 1 ? v[0] : v[nb]) : m == MODE_REV ? v[rb] : v[b];
    end
    return r;
  endfunction
endpackage

// File: rtl/fft_pingpong_addr_gen_if.sv
// fft_pingpong_addr_gen_if: write-stream and banked-read handshake bundle of the ping-pong address generator
//   master: the generator (drives ready, enables, addresses, strobes)
//   slave:  the stream source / butterfly consumer side
interface fft_pingpong_addr_gen_if #(
  parameter int AddrWidth = 5,
  parameter int NumBanks = 4
);
  logic flush_i;
  logic [1:0] mode_i;
  logic in_valid_i;
  logic in_ready_o;
  logic [2*NumBanks-1:0] wen_o;
  logic [AddrWidth-1:0] addr_wr_o;
  logic rd_ready_i;
  logic [2*NumBanks-1:0] ren_o;
  logic [AddrWidth-1:0] addr_rd_o;
  logic rd_valid_o;
  logic start_fft_o;
  logic frame_last_o;
  modport master (
    input flush_i, mode_i, in_valid_i, rd_ready_i,
    output in_ready_o, wen_o, addr_wr_o, ren_o, addr_rd_o, rd_valid_o, start_fft_o, frame_last_o
  );
  modport slave (
    output flush_i, mode_i, in_valid_i, rd_ready_i,
    input in_ready_o, wen_o, addr_wr_o, ren_o, addr_rd_o, rd_valid_o, start_fft_o, frame_last_o
  );
endinterface

// File: rtl/fft_perm_idx.sv
// fft_perm_idx: combinational W-bit index permutation (linear / rotate-right / bit-reverse)
//   idx  in  W  index to permute
//   mode in  2  permutation mode
//   perm out W  permuted index
module fft_perm_idx import fft_mem_pkg::*; #(
  parameter int W = 3
) (
  input  logic [W-1:0] idx,
  input  mode_e        mode,
  output logic [W-1:0] perm
);
  logic [7:0] full_perm;
  always_comb full_perm = permute(8'(idx), W, mode);
  assign perm = full_perm[W-1:0];
endmodule

// File: rtl/fft_pingpong_addr_gen.sv
// fft_pingpong_addr_gen: double-buffered banked SRAM write/read address generator between FFT input and stage 2
//   clk_i, rst_i (async, active-high)
//   bus.master: flush_i, mode_i, in_valid_i/in_ready_o, wen_o/addr_wr_o,
//               rd_ready_i, ren_o/addr_rd_o, rd_valid_o, start_fft_o, frame_last_o
module fft_pingpong_addr_gen import fft_mem_pkg::*; #(
  parameter int AddrWidth = 5,
  parameter int NumBanks = 4,
  parameter int PermBits = 3
) (
  input logic clk_i,
  input logic rst_i,
  fft_pingpong_addr_gen_if.master bus
);
  localparam int CntW = cnt_width(AddrWidth, NumBanks);
  localparam logic [AddrWidth-1:0] LowMask = AddrWidth'((1 << PermBits) - 1);
  logic [CntW-1:0] wcnt, rcnt;
  logic wr_sel, rd_sel, rd_valid, wr_acc, rd_iss;
  logic [1:0] full;
  mode_e mode_q, mode_cur;
  logic [PermBits-1:0] perm;
  // The mode is taken live on the first sample of a frame and frozen for the rest of it.
  always_comb begin
    mode_cur = wcnt == '0 ? mode_e'(bus.mode_i) : mode_q;
    wr_acc = bus.in_valid_i & ~full[wr_sel] & ~bus.flush_i;
    rd_iss = full[rd_sel] & bus.rd_ready_i & ~bus.flush_i;
  end
  fft_perm_idx #(.W(PermBits)) u_perm (.idx(wcnt[PermBits-1:0]), .mode(mode_cur), .perm(perm));
  // {sel, bank} equals sel*NumBanks + bank because NumBanks is a power of two.
  assign bus.in_ready_o = ~full[wr_sel];
  assign bus.wen_o = wr_acc ? (2*NumBanks)'(1) << {wr_sel, wcnt[CntW-1:AddrWidth]} : '0;
  assign bus.addr_wr_o = (wcnt[AddrWidth-1:0] & ~LowMask) | AddrWidth'(perm);
  assign bus.ren_o = rd_iss ? (2*NumBanks)'(1) << {rd_sel, rcnt[CntW-1:AddrWidth]} : '0;
  assign bus.addr_rd_o = rcnt[AddrWidth-1:0];
  assign bus.start_fft_o = rd_iss & (rcnt == '0);
  assign bus.frame_last_o = rd_iss & (&rcnt);
  assign bus.rd_valid_o = rd_valid;
  // A completing write and a completing read always target different sets, so both full bits update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wcnt <= '0;
      rcnt <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      full <= '0;
      mode_q <= MODE_LIN;
      rd_valid <= 1'b0;
    end else if (bus.flush_i) begin
      wcnt <= '0;
      rcnt <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      full <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_iss;
      if (wr_acc) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == '0) mode_q <= mode_cur;
        if (&wcnt) begin
          full[wr_sel] <= 1'b1;
          wr_sel <= ~wr_sel;
        end
      end
      if (rd_iss) begin
        rcnt <= rcnt + 1'b1;
        if (&rcnt) begin
          full[rd_sel] <= 1'b0;
          rd_sel <= ~rd_sel;
        end
      end
    end
  end
endmodule

// File: tb/tb_fft_pingpong_addr_gen.sv
// tb_fft_pingpong_addr_gen: directed stimulus with a frame-level reference model checked every cycle
module tb_fft_pingpong_addr_gen;
  localparam int A = 5, NB = 4, P = 3;
  localparam int D = 1 << A;
  localparam int FR = D * NB;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vec = 0, err = 0;
  int cyc = 0;
  fft_pingpong_addr_gen_if #(.AddrWidth(A), .NumBanks(NB)) bus ();
  fft_pingpong_addr_gen #(.AddrWidth(A), .NumBanks(NB), .PermBits(P)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic int perm_m(input int x, input int m);
    int r;
    if (m == 1) return (x >> 1) | ((x & 1) << (P - 1));
    if (m == 2) begin
      r = 0;
      for (int i = 0; i < P; i++) if ((x & (1 << i)) != 0) r |= 1 << (P - 1 - i);
      return r;
    end
    return x;
  endfunction
  // Frame-level model: frames written/read since reset and positions inside the current frames.
  int wf = 0, rf = 0, wpos = 0, rpos = 0, cur_mode = 0, prev_iss = 0;
  logic [31:0] logw[$], loga[$], st_q[$], st_ren[$], st_addr[$], lq[$];
  always @(negedge clk) begin
    int ready, acc, iss, m, base, lo;
    if (rst) begin
      wf = 0; rf = 0; wpos = 0; rpos = 0; prev_iss = 0; cur_mode = 0;
    end
    ready = (wf - rf) < 2;
    acc = (bus.in_valid_i && ready && !bus.flush_i) ? 1 : 0;
    iss = (wf > rf && bus.rd_ready_i && !bus.flush_i) ? 1 : 0;
    m = wpos == 0 ? int'(bus.mode_i) : cur_mode;
    base = wpos % D;
    lo = base % (1 << P);
    chk("in_ready", 32'(bus.in_ready_o), 32'(ready));
    chk("wen", 32'(bus.wen_o), acc != 0 ? 32'(1) << ((wf % 2) * NB + wpos / D) : 32'd0);
    chk("addr_wr", 32'(bus.addr_wr_o), 32'(base - lo + perm_m(lo, m)));
    chk("ren", 32'(bus.ren_o), iss != 0 ? 32'(1) << ((rf % 2) * NB + rpos / D) : 32'd0);
    chk("addr_rd", 32'(bus.addr_rd_o), 32'(rpos % D));
    chk("start_fft", 32'(bus.start_fft_o), 32'(iss != 0 && rpos == 0));
    chk("frame_last", 32'(bus.frame_last_o), 32'(iss != 0 && rpos == FR - 1));
    chk("rd_valid", 32'(bus.rd_valid_o), 32'(prev_iss));
    if (bus.wen_o != 0) begin
      logw.push_back(32'(bus.wen_o));
      loga.push_back(32'(bus.addr_wr_o));
    end
    if (bus.start_fft_o) begin
      st_q.push_back(32'(cyc));
      st_ren.push_back(32'(bus.ren_o));
      st_addr.push_back(32'(bus.addr_rd_o));
    end
    if (bus.frame_last_o) lq.push_back(32'(cyc));
    if (!rst) begin
      if (bus.flush_i) begin
        wf = 0; rf = 0; wpos = 0; rpos = 0;
      end else begin
        if (acc != 0) begin
          if (wpos == 0) cur_mode = m;
          wpos++;
          if (wpos == FR) begin wpos = 0; wf++; end
        end
        if (iss != 0) begin
          rpos++;
          if (rpos == FR) begin rpos = 0; rf++; end
        end
      end
      prev_iss = iss;
    end
  end
  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return i < q.size() ? q[i] : 32'hDEAD_BEEF;
  endfunction
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.rd_ready_i = 1'b0;
    bus.mode_i = 2'b00;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    chk("rst_rd_valid", 32'(bus.rd_valid_o), 32'd0);
    step(2);
    rst = 1'b0;
    logw.delete(); loga.delete(); st_q.delete(); st_ren.delete(); st_addr.delete(); lq.delete();
  endtask
  int rot_exp[8] = '{0, 4, 1, 5, 2, 6, 3, 7};
  int rev_exp[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  initial begin
    int base, n0, sc, hit;
    bus.in_valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.rd_ready_i = 1'b0;
    bus.mode_i = 2'b00;
    // Continuous mode-01 streaming: four frames in, ping-pong reads.
    do_reset();
    base = cyc;
    bus.mode_i = 2'b01;
    bus.in_valid_i = 1'b1;
    bus.rd_ready_i = 1'b1;
    step(512);
    bus.in_valid_i = 1'b0;
    step(140);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rot_wen%0d", i), at(logw, i), 32'h01);
      chk($sformatf("rot_addr%0d", i), at(loga, i), 32'(rot_exp[i]));
    end
    chk("wen_write32", at(logw, 32), 32'h02);
    chk("wen_write96", at(logw, 96), 32'h08);
    chk("wen_frame2", at(logw, 128), 32'h10);
    chk("first_start_cycle", at(st_q, 0) - 32'(base), 32'd128);
    chk("first_start_ren", at(st_ren, 0), 32'h01);
    chk("first_start_addr", at(st_addr, 0), 32'd0);
    chk("first_last_cycle", at(lq, 0) - 32'(base), 32'd255);
    for (int i = 0; i < 3; i++) chk($sformatf("last_period%0d", i), at(lq, i + 1) - at(lq, i), 32'd128);
    // Bit-reverse, then reserved mode behaving as linear.
    do_reset();
    bus.mode_i = 2'b10;
    bus.in_valid_i = 1'b1;
    step(8);
    bus.in_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) chk($sformatf("rev_addr%0d", i), at(loga, i), 32'(rev_exp[i]));
    do_reset();
    bus.mode_i = 2'b11;
    bus.in_valid_i = 1'b1;
    step(8);
    bus.in_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) chk($sformatf("res_addr%0d", i), at(loga, i), 32'(i));
    // Backpressure with both sets full.
    do_reset();
    bus.in_valid_i = 1'b1;
    step(260);
    chk("bp_in_ready_full", 32'(bus.in_ready_o), 32'd0);
    chk("bp_writes", 32'(logw.size()), 32'd256);
    bus.rd_ready_i = 1'b1;
    hit = 0;
    for (int i = 0; i < 200 && hit == 0; i++) begin
      @(negedge clk);
      if (bus.frame_last_o) hit = 1;
    end
    chk("bp_last_seen", 32'(hit), 32'd1);
    chk("bp_ready_at_last", 32'(bus.in_ready_o), 32'd0);
    @(posedge clk);
    #1;
    chk("bp_ready_after_last", 32'(bus.in_ready_o), 32'd1);
    bus.in_valid_i = 1'b0;
    step(300);
    // Mode change mid-frame applies to the next frame only.
    do_reset();
    bus.in_valid_i = 1'b1;
    bus.rd_ready_i = 1'b1;
    step(50);
    bus.mode_i = 2'b10;
    step(90);
    bus.in_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("mid_addr%0d", 50 + i), at(loga, 50 + i), 32'(18 + i));
      chk($sformatf("next_addr%0d", i), at(loga, 128 + i), 32'(rev_exp[i]));
    end
    step(260);
    // Flush at write 70 of the second frame, then a reset mid-read.
    do_reset();
    bus.in_valid_i = 1'b1;
    bus.rd_ready_i = 1'b1;
    step(198);
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk("flush_wen", 32'(bus.wen_o), 32'd0);
    chk("flush_ren", 32'(bus.ren_o), 32'd0);
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    n0 = logw.size();
    step(1);
    chk("post_flush_wen", at(logw, n0), 32'h01);
    chk("post_flush_addr", at(loga, n0), 32'd0);
    step(139);
    rst = 1'b1;
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_wen", 32'(bus.wen_o), 32'd0);
    chk("rst_mid_ren", 32'(bus.ren_o), 32'd0);
    chk("rst_mid_rd_valid", 32'(bus.rd_valid_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid_i = 1'b1;
    n0 = logw.size();
    sc = st_q.size();
    step(128);
    chk("post_rst_wen", at(logw, n0), 32'h01);
    chk("post_rst_addr", at(loga, n0), 32'd0);
    chk("no_early_start", 32'(st_q.size()), 32'(sc));
    step(1);
    chk("start_after_frame", 32'(st_q.size()), 32'(sc + 1));
    bus.in_valid_i = 1'b0;
    step(140);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", err);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fft_pingpong_addr_gen.md
# fft_pingpong_addr_gen

Parametrised ping-pong address generator between the FFT input stream and the stage-2 banked SRAM array. Each incoming sample is written into one of NumBanks banks of the current write set, with a selectable permutation of the low address bits. Full sets are read back linearly to the butterfly datapath with backpressure, while the other set fills. Successor of the fixed 4-bank single-buffer generator: adds bank/depth parameters, permutation modes, double buffering, per-sample handshakes and flush.

## Interface
- AddrWidth, 5: log2 of words per bank; Depth = 2**AddrWidth.
- NumBanks, 4: banks per set; power of two, 2..8.
- PermBits, 3: low address bits subject to permutation; 1..AddrWidth.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous abort of both frames.
- mode_i  in  2  write permutation: 00 linear, 01 rotate-right of low PermBits (0,4,1,5,2,6,3,7 for PermBits=3), 10 bit-reverse of low PermBits, 11 reserved, treated as 00.
- in_valid_i  in  1  write sample present.
- in_ready_o  out  1  write set has room.
- wen_o  out  2*NumBanks  one-hot bank write enable; bit = set*NumBanks + bank.
- addr_wr_o  out  AddrWidth  write address.
- rd_ready_i  in  1  consumer accepts a read this cycle.
- ren_o  out  2*NumBanks  one-hot bank read enable, same indexing.
- addr_rd_o  out  AddrWidth  read address.
- rd_valid_o  out  1  SRAM read data valid (ren issued previous cycle).
- start_fft_o  out  1  pulse with the first read of a frame.
- frame_last_o  out  1  pulse with the last read of a frame.

## Operation
- State: wcnt, rcnt (CntW = AddrWidth + log2(NumBanks) bits), wr_sel, rd_sel, full[1:0], mode_q.
- Write accept = in_valid_i & in_ready_o; in_ready_o = ~full[wr_sel].
- Write bank = wcnt[CntW-1:AddrWidth]. Address = wcnt[AddrWidth-1:0] with low PermBits replaced per the mode.
- Mode is mode_i when wcnt==0, else mode_q. mode_q is loaded on the accept with wcnt==0.
- On accept with wcnt == all-ones: full[wr_sel]<=1, wr_sel toggles, wcnt wraps to 0.
- Read issue = full[rd_sel] & rd_ready_i. Read bank = rcnt high bits; addr_rd_o = rcnt low bits, linear.
- On issue with rcnt == all-ones: full[rd_sel]<=0, rd_sel toggles, rcnt wraps to 0.
- Write completion and read completion in the same cycle touch different sets. Both take effect.
- flush_i clears wcnt, rcnt, sels and full. It suppresses wen_o/ren_o and start/last in that cycle. rd_valid_o still reflects the previous cycle's issue.

## Timing
- wen_o, addr_wr_o, in_ready_o, ren_o, addr_rd_o, start_fft_o and frame_last_o are combinational from registers and inputs; zero latency.
- wen_o is zero unless a write is accepted. ren_o is zero unless a read is issued.
- rd_valid_o is registered: 1 exactly one cycle after each issue.
- Reset values: counters, sels, full, mode_q and rd_valid_o are 0. in_ready_o=1; all other outputs 0.
- Reset mid-frame discards all data and is effective immediately (asynchronous).
- Steady state with in_valid_i and rd_ready_i held high: one frame per Depth*NumBanks cycles, no bubbles. First start_fft_o comes Depth*NumBanks cycles after the first write.

## Structure
- Package fft_mem_pkg: mode enum (MODE_LIN, MODE_ROT, MODE_REV), a permute function, and a cnt_t typedef helper.
- Sub-module fft_perm_idx: combinational PermBits-wide permutation. Also reused by later stages.
- The rest is a single module.

## Test plan
- Defaults, mode 01, continuous valid/ready, 128 writes:
  - writes 0..7 go to bank 0 (wen_o=8'h01) at addresses 0,4,1,5,2,6,3,7; write 32 selects bank 1.
  - start_fft_o fires in cycle 128 with ren_o=8'h01, addr_rd_o=0.
- Mode 10 with PermBits=3: write sequence 0..7 gives addresses 0,4,2,6,1,5,3,7. Mode 11 gives linear.
- Ping-pong: three back-to-back frames with rd_ready_i=1.
  - Frame 2 writes use wen_o bits [7:4] while frame 1 reads use ren_o bits [3:0].
  - in_ready_o never drops; frame_last_o pulses every 128 cycles.
- Backpressure: rd_ready_i=0 with both sets full drops in_ready_o to 0. Releasing one read frame sets in_ready_o to 1 in the cycle after frame_last_o.
- Mode change mid-frame: mode_i toggles at write 50. The addresses keep the mode sampled at write 0; the next frame uses the new mode.
- flush_i at write 70, then rst_i pulse mid-read: all enables are 0 in that cycle. The next write goes to bank 0 of set 0, address 0, and no start_fft_o comes until 128 new writes.
